seven_seg_scanner: RTL and testbench

//   Consumes the cpu's memory-mapped 16-bit display_out word and drives a 4-digit

---
 rtl/seven_seg_scanner.sv | 102 ++++++++++
 tb/tb_seven_seg_scanner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode hex scanner; outputs are registered one cycle after scan state, and en=0 freezes all state and pins.
// Defining SEVEN_SEG_LZ_BLANK_EN blanks leading-zero digits 1..3; digit 0 always shows.
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD = CW'(GUARD_CYCLES);

  logic [CW-1:0] div_cnt;
  logic [1:0]    digit;
  logic [15:0]   shadow_val;
  logic [3:0]    shadow_dp;

  logic [3:0]    nibble;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;
`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic [15:0]   upper;
`endif

  // Active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    nibble  = shadow_val[{digit, 2'b00} +: 4];
    an_nxt  = 4'hF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    upper   = shadow_val >> {digit, 2'b00};
`endif
    // First GUARD cycles of each slot keep all anodes dark to hide ghosting
    if (div_cnt >= GUARD) begin
      an_nxt  = ~(4'b0001 << digit);
      seg_nxt = ~hex7(nibble);
      dp_nxt  = ~shadow_dp[digit];
`ifdef SEVEN_SEG_LZ_BLANK_EN
      if (digit != 2'd0 && upper == 16'h0000) seg_nxt = 7'h7F;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      digit      <= 2'd0;
      shadow_val <= 16'h0000;
      shadow_dp  <= 4'h0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
    end else if (en) begin
      if (div_cnt == LAST) begin
        div_cnt <= '0;
        digit   <= digit + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      // Latch only at frame start so a frame never mixes two words
      if (digit == 2'd0 && div_cnt == '0) begin
        shadow_val <= value;
        shadow_dp  <= dp_en;
      end
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with REFRESH_DIV=8, GUARD_CYCLES=2; a frame-position model predicts the pins.
module tb_seven_seg_scanner;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_en = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int errors = 0;
  int checks = 0;

  // Model: position within the frame in en-cycles, plus the latched word
  int          m_pos = 0;
  logic [15:0] m_val = 16'h0000;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1;

  seven_seg_scanner #(.REFRESH_DIV(DIV), .GUARD_CYCLES(GUARD)) dut (
    .clk(clk), .rst(rst), .en(en), .value(value), .dp_en(dp_en),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic [15:0] v, input logic [3:0] d);
    int slot, cyc, nib, upper;
    rst = r; en = e; value = v; dp_en = d;
    @(posedge clk);
    if (r) begin
      m_pos = 0; m_val = 16'h0000; m_dp = 4'h0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else if (e) begin
      slot = m_pos / DIV;
      cyc  = m_pos % DIV;
      if (cyc < GUARD) begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        nib    = (m_val / (1 << (4 * slot))) % 16;
        upper  = m_val / (1 << (4 * slot));
        exp_an = 4'hF ^ 4'(1 << slot);
        exp_seg = SEG_LUT[nib];
        exp_dp = !m_dp[slot];
`ifdef SEVEN_SEG_LZ_BLANK_EN
        if (slot >= 1 && upper == 0) exp_seg = 7'h7F;
`endif
      end
      if (m_pos == 0) begin
        m_val = v; m_dp = d;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h1234, 4'h0);
      checks++;
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        errors++;
        $display("FAIL reset i=%0d got an=%h seg=%h dp=%b want an=f seg=7f dp=1", i, an, seg, dp);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 16'h1234, 4'h0);
      checks++;
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        errors++;
        $display("FAIL guard_after_reset i=%0d got an=%h seg=%h dp=%b want an=f seg=7f dp=1", i, an, seg, dp);
      end
    end
  endtask

  task automatic test_scan();
    step(1'b1, 1'b0, 16'h1234, 4'h0);
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b1, 16'h1234, 4'h0);
      checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL scan i=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", i, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (i == 2 || i == 26) begin
        checks++;
        if ({an, seg} !== ((i == 2) ? {4'b1110, 7'h19} : {4'b0111, 7'h79})) begin
          errors++;
          $display("FAIL scan_fixed i=%0d got an=%h seg=%h", i, an, seg);
        end
      end
    end
  endtask

  task automatic test_frame_latch();
    logic [15:0] v;
    step(1'b1, 1'b0, 16'h1234, 4'h0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      v = (i < 2 * DIV) ? 16'h1234 : 16'hABCD;
      step(1'b0, 1'b1, v, 4'h0);
      checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL latch i=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", i, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (i == 26 || i == FRAME + 26) begin
        checks++;
        if (seg !== ((i == 26) ? 7'h79 : 7'h08)) begin
          errors++;
          $display("FAIL latch_fixed i=%0d got seg=%h", i, seg);
        end
      end
    end
  endtask

  task automatic test_freeze();
    logic [3:0] h_an; logic [6:0] h_seg; logic h_dp;
    step(1'b1, 1'b0, 16'h9E07, 4'b0101);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 16'h9E07, 4'b0101);
    h_an = exp_an; h_seg = exp_seg; h_dp = exp_dp;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 16'hFFFF, 4'hF);
      checks++;
      if ({an, seg, dp} !== {h_an, h_seg, h_dp} || dut.div_cnt !== 3'(m_pos % DIV)) begin
        errors++;
        $display("FAIL freeze i=%0d got an=%h seg=%h dp=%b cnt=%0d want an=%h seg=%h dp=%b cnt=%0d",
                 i, an, seg, dp, dut.div_cnt, h_an, h_seg, h_dp, m_pos % DIV);
      end
    end
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b1, 16'h9E07, 4'b0101);
      checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL resume i=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", i, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] want2;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    want2 = 7'h7F;
`else
    want2 = 7'h40;
`endif
    step(1'b1, 1'b0, 16'h0042, 4'b0100);
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b1, 16'h0042, 4'b0100);
      checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL lz i=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", i, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (i == 2 * DIV + 2) begin
        checks++;
        if ({seg, dp} !== {want2, 1'b0}) begin
          errors++;
          $display("FAIL lz_digit2 got seg=%h dp=%b want seg=%h dp=0", seg, dp, want2);
        end
      end
    end
    step(1'b1, 1'b0, 16'h0000, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0000, 4'h0);
    checks++;
    if ({an, seg} !== {4'b1110, 7'h40}) begin
      errors++;
      $display("FAIL zero_digit0 got an=%h seg=%h want an=e seg=40", an, seg);
    end
  endtask

  task automatic test_reset_midframe();
    step(1'b1, 1'b0, 16'h1234, 4'h0);
    for (int i = 0; i < 2 * DIV + 4; i++) step(1'b0, 1'b1, 16'h1234, 4'h0);
    step(1'b1, 1'b1, 16'h5678, 4'h0);
    checks++;
    if (an !== 4'hF || dut.digit !== 2'd0) begin
      errors++;
      $display("FAIL midreset got an=%h digit=%0d want an=f digit=0", an, dut.digit);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h5678, 4'h0);
    checks++;
    if ({an, seg} !== {4'b1110, 7'h00}) begin
      errors++;
      $display("FAIL midreset_digit0 got an=%h seg=%h want an=e seg=00", an, seg);
    end
  endtask

  task automatic test_random();
    logic [15:0] v; logic [3:0] d;
    v = 16'($urandom); d = 4'($urandom);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        v = 16'($urandom);
        if ($urandom_range(0, 2) == 0) v = v & 16'h00FF;
        d = 4'($urandom);
      end
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), v, d);
      checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL random i=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", i, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_latch();
    test_freeze();
    test_leading_zero();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
